fifo_read_sched: RTL and testbench
==================================

// Module: fifo_read_sched
// PURPOSE
//  Round-robin scheduler sharing one downstream byte link between N_CH fifo_read channels.
//  - On each frame trigger, snapshots which channels are ready and enabled.
//  - Serves those channels one at a time: raises fs, waits for fd, drops fs, waits for fd to clear.
//  - Drives sel to the external fifo_rxd/fifo_rxen mux; sits between frame timing logic and the readers.
// PARAMETERS
//  N_CH         4     number of fifo_read channels (2..16)
//  SEL_W        2     sel width, = $clog2(N_CH)
//  TIMEOUT_CYC  4096  max cycles in WAIT/REL before abort (FRS_TIMEOUT_EN only)
//  CNT_W        16    frame counter width
// PORTS
//  clk        in   1      clock (posedge)
//  rst        in   1      reset, asynchronous, active-high
//  start      in   1      frame trigger pulse, sampled in IDLE only
//  chan_en    in   N_CH   static per-channel enable
//  chan_rdy   in   N_CH   channel has a frame of data_len bytes buffered
//  fs         out  N_CH   per-channel start strobe to fifo_read (one-hot or zero)
//  fd         in   N_CH   per-channel done from fifo_read
//  sel        out  SEL_W  index of channel owning the link
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse at frame end
//  err        out  1      one-cycle pulse on channel abort
//  frame_cnt  out  CNT_W  completed frames, wraps at 2^CNT_W
//  so         out  3      current state code
// BEHAVIOUR
//  Reset: state=IDLE; fs=0, sel=0, busy=0, done=0, err=0, frame_cnt=0; pend=0; rr ptr=0. All outputs registered.
//  States: IDLE=0, ARB=1, REQ=2, WAIT=3, REL=4, DONE=5; codes 6,7 -> IDLE.
//  IDLE: on start=1, pend <= chan_rdy & chan_en -> ARB. start in any other state is ignored (not queued).
//  ARB:
//   - pend==0 -> DONE.
//   - Otherwise sel <= first set bit of pend at or above ptr, wrapping modulo N_CH -> REQ.
//  REQ: fs[sel] goes high on the next clock edge -> WAIT.
//   - Latency start->fs: 3 clocks (IDLE, ARB, REQ).
//  WAIT: fs[sel] held high; fd[sel]=1 -> REL. fd bits of other channels are ignored.
//  REL: fs[sel]=0.
//   - On fd[sel]=0: clear pend[sel]; ptr <= sel+1 (wraps N_CH-1 -> 0) -> ARB.
//   - Same-cycle fd rise/fall glitches are tolerated: only the level sampled at posedge counts.
//  DONE: done=1 for one cycle; frame_cnt+1 -> IDLE.
//  chan_rdy changes after the snapshot do not affect the current frame.
//  Empty snapshot: IDLE->ARB->DONE, done pulse, frame_cnt still increments.
//  fd sampled at posedge; readers update state on negedge, so fd is stable at sample.
//  rst mid-frame: fs drops immediately (async); pend is lost; no done pulse.
//  ptr persists across frames, giving fairness over successive frames.
// CONFIGURATION
//  FRS_TIMEOUT_EN defined:
//   - tmo counter clears on REQ, counts in WAIT and REL.
//   - At tmo==TIMEOUT_CYC-1: err=1 for one cycle; fs[sel]=0; pend[sel] cleared; ptr <= sel+1 -> ARB.
//   - The aborted channel is never served again in this frame.
//  FRS_TIMEOUT_EN undefined: no counter; err tied 0; WAIT/REL block indefinitely.
// STRUCTURE
//  fifo_sched_pkg: state localparams IDLE..DONE, SEL_W derivation, TIMEOUT_CYC default.
//  Sub-module rr_pick: combinational (pend, ptr) -> (grant_idx, any); rotate then priority-encode.
//  Top holds the FSM, pend/ptr/sel registers, frame_cnt and the optional tmo counter.
// TESTING
//  1 chan_en=4'hF, chan_rdy=4'b1011, start; bench readers assert fd 5 clk after fs
//    -> served order 0,1,3; one done; frame_cnt=1.
//  2 Repeat with ptr=2 from a prior frame that ended on ch1, rdy=4'hF -> order 2,3,0,1.
//  3 chan_rdy=0, start -> fs never rises; done 2 clk after start; frame_cnt increments.
//  4 start pulsed during WAIT -> ignored; exactly one done per accepted start.
//  5 FRS_TIMEOUT_EN, TIMEOUT_CYC=16, ch1 never asserts fd
//    -> err at 16th WAIT cycle; fs[1]=0; ch2 served next; done still pulses.
//  6 rst asserted in WAIT -> fs=0 with no clock edge; state=IDLE; frame_cnt=0; next start works normally.

Source files
------------

// File: rtl/fifo_read_sched_pkg.sv
// Shared types and defaults for the fifo_read round-robin scheduler.
package fifo_read_sched_pkg;

    localparam int unsigned N_CH_DEF        = 4;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned TIMEOUT_CYC_DEF = 4096;

    // Scheduler state codes; the so output exposes these directly
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_REL  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Width of a channel index; never narrower than one bit
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_read_sched_rr_pick.sv
// Round-robin pick: first set bit of pend at or above ptr, wrapping modulo N_CH.
module fifo_read_sched_rr_pick #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N_CH-1:0]  i_pend,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [N_CH-1:0]  w_rot;
    logic [SEL_W:0]   w_idx;
    logic [SEL_W-1:0] w_off;
    logic [SEL_W:0]   w_sum;

    // Rotate pend so the channel at ptr lands on bit 0
    always_comb begin
        w_rot = '0;
        w_idx = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            w_idx = {1'b0, i_ptr} + (SEL_W+1)'(i);
            if (w_idx >= (SEL_W+1)'(N_CH)) begin
                w_idx = w_idx - (SEL_W+1)'(N_CH);
            end
            w_rot[i] = i_pend[w_idx[SEL_W-1:0]];
        end
    end

    // Lowest set bit of the rotated vector is the offset from ptr
    always_comb begin
        w_off = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    // Undo the rotation to recover the absolute channel index
    always_comb begin
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (SEL_W+1)'(N_CH)) begin
            w_sum = w_sum - (SEL_W+1)'(N_CH);
        end
    end

    assign o_grant_idx = w_sum[SEL_W-1:0];
    assign o_any       = |i_pend;

endmodule

// File: rtl/fifo_read_sched.sv
// Round-robin scheduler sharing one byte link between N_CH fifo_read channels.
// Optional per-channel watchdog enabled by defining FRS_TIMEOUT_EN.
module fifo_read_sched
    import fifo_read_sched_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned SEL_W = sel_width(N_CH),
    parameter int unsigned CNT_W = CNT_W_DEF
`ifdef FRS_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [N_CH-1:0]  i_chan_en,
    input  logic [N_CH-1:0]  i_chan_rdy,
    output logic [N_CH-1:0]  o_fs,
    input  logic [N_CH-1:0]  i_fd,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [2:0]       o_so
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    state_t           r_state;
    logic [N_CH-1:0]  r_pend;
    logic [N_CH-1:0]  r_fs;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_frame_cnt;

    logic [SEL_W-1:0] w_grant;
    logic             w_any;
    logic [SEL_W-1:0] w_ptr_nxt;

    fifo_read_sched_rr_pick #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .i_pend      (r_pend),
        .i_ptr       (r_ptr),
        .o_grant_idx (w_grant),
        .o_any       (w_any)
    );

    // Pointer moves just past the channel that was served or aborted
    assign w_ptr_nxt = (r_sel == LAST_CH) ? '0 : r_sel + SEL_W'(1);

`ifdef FRS_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    logic             w_tmo_hit;

    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign o_err     = r_err;
`else
    assign o_err = 1'b0;
`endif

    // Frame FSM: snapshot, arbitrate, handshake each channel, then report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend      <= '0;
            r_fs        <= '0;
            r_sel       <= '0;
            r_ptr       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
`ifdef FRS_TIMEOUT_EN
            r_tmo       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef FRS_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pend  <= i_chan_rdy & i_chan_en;
                        r_busy  <= 1'b1;
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (!w_any) begin
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_state     <= S_DONE;
                    end else begin
                        r_sel   <= w_grant;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_fs    <= N_CH'(1) << r_sel;
                    r_state <= S_WAIT;
`ifdef FRS_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                end
                S_WAIT: begin
`ifdef FRS_TIMEOUT_EN
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (w_tmo_hit) begin
                        r_err         <= 1'b1;
                        r_fs          <= '0;
                        r_pend[r_sel] <= 1'b0;
                        r_ptr         <= w_ptr_nxt;
                        r_state       <= S_ARB;
                    end else
`endif
                    if (i_fd[r_sel]) begin
                        r_fs    <= '0;
                        r_state <= S_REL;
                    end
                end
                S_REL: begin
`ifdef FRS_TIMEOUT_EN
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (w_tmo_hit) begin
                        r_err         <= 1'b1;
                        r_pend[r_sel] <= 1'b0;
                        r_ptr         <= w_ptr_nxt;
                        r_state       <= S_ARB;
                    end else
`endif
                    if (!i_fd[r_sel]) begin
                        r_pend[r_sel] <= 1'b0;
                        r_ptr         <= w_ptr_nxt;
                        r_state       <= S_ARB;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_fs    <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_fs        = r_fs;
    assign o_sel       = r_sel;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_frame_cnt = r_frame_cnt;
    assign o_so        = r_state;

endmodule

// File: tb/tb_fifo_read_sched.sv
// Testbench for fifo_read_sched: open-loop timeline model plus literal pins.
module tb_fifo_read_sched;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [3:0]  i_chan_en, i_chan_rdy, i_fd;
    logic [3:0]  o_fs;
    logic [1:0]  o_sel;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_frame_cnt;
    logic [2:0]  o_so;

    fifo_read_sched #(
        .N_CH  (4),
        .SEL_W (2),
        .CNT_W (16)
`ifdef FRS_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TMO)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_chan_en   (i_chan_en),
        .i_chan_rdy  (i_chan_rdy),
        .o_fs        (o_fs),
        .i_fd        (i_fd),
        .o_sel       (o_sel),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_frame_cnt (o_frame_cnt),
        .o_so        (o_so)
    );

    always #5 clk = ~clk;

    // Edge index: value n is seen between posedge n and posedge n+1
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Frame plan: served order and the edges where each handshake phase starts
    int t0 = BIG, E = BIG, np = 0, base = 0, fc = 0, mptr = 0;
    int ord[4], R[4], F[4], L[4], D[4], H[4];
    bit ab[4];
    bit chk_en = 1'b0;

    // Observations for the literal pins
    int seen[$];
    int first_fs_edge = -1, done_edge = -1, err_edge = -1, done_cnt = 0;
    logic [3:0] prev_fs = 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h edge=%0d", nm, act, exp, cyc);
        end
    endtask

    // Expected outputs after edge e, derived from the frame timeline
    function automatic void model_at(input int e, output logic [3:0] fs, output logic fs_on,
                                     output logic [1:0] sel, output logic busy, output logic done,
                                     output logic err, output logic [15:0] cnt, output logic [2:0] so);
        fs = 4'h0; fs_on = 1'b0; sel = 2'd0; err = 1'b0; so = 3'd0;
        busy = (e >= t0) && (e <= E);
        done = (e == E);
        cnt  = 16'(base + ((e >= E) ? 1 : 0));
        if (busy) begin
            if (e == t0) so = 3'd1;
            for (int k = 0; k < np; k++) begin
                if (e == R[k] - 1) so = 3'd2;
                if (e >= R[k] && e < F[k]) begin
                    so = 3'd3; fs = 4'(1 << ord[k]); fs_on = 1'b1; sel = 2'(ord[k]);
                end
                if (e >= F[k] && e < L[k]) so = 3'd4;
                if (e == L[k]) so = 3'd1;
                if (ab[k] && e == F[k]) err = 1'b1;
            end
            if (e == E) so = 3'd5;
        end
    endfunction

    // Compare process and monitor, away from the active edge
    always @(negedge clk) begin : cmp
        logic [3:0]  efs;
        logic        eon, ebusy, edone, eerr;
        logic [1:0]  esel;
        logic [15:0] ecnt;
        logic [2:0]  eso;
        if (chk_en) begin
            model_at(cyc, efs, eon, esel, ebusy, edone, eerr, ecnt, eso);
            chk("fs", o_fs, efs);
            if (eon) chk("sel", o_sel, esel);
            chk("busy", o_busy, ebusy);
            chk("done", o_done, edone);
            chk("err", o_err, eerr);
            chk("frame_cnt", o_frame_cnt, ecnt);
            chk("state", o_so, eso);
            if (o_fs != 4'h0 && prev_fs == 4'h0) begin
                for (int c = 0; c < N; c++) if (o_fs[c]) seen.push_back(c);
                if (first_fs_edge < 0) first_fs_edge = cyc;
            end
            if (o_done) begin done_cnt++; done_edge = cyc; end
            if (o_err) err_edge = cyc;
            prev_fs = o_fs;
        end
    end

    // Build the timeline for a frame accepted at edge t
    task automatic plan(input logic [3:0] snap_in, input int t, input int dfix, input int hfix,
                        input logic [3:0] abm);
        logic [3:0] s;
        int p, e;
        s = snap_in; p = mptr; np = 0;
        while (s != 4'h0) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (p + j) % N;
                if (s[c]) begin
                    ord[np] = c; s[c] = 1'b0; p = (c + 1) % N; np++;
                    break;
                end
            end
        end
        if (np > 0) mptr = p;
        base = fc; fc++;
        e = t;
        for (int k = 0; k < np; k++) begin
            R[k]  = e + 2;
            D[k]  = (dfix > 0) ? dfix : int'($urandom_range(1, 5));
            H[k]  = (hfix > 0) ? hfix : int'($urandom_range(1, 4));
            ab[k] = abm[ord[k]];
            F[k]  = ab[k] ? R[k] + TMO : R[k] + D[k];
            L[k]  = ab[k] ? F[k] : F[k] + H[k];
            e     = L[k];
        end
        E  = e + 1;
        t0 = t;
    endtask

    // Inputs for sampling edge x; fd follows the plan, other lines may be noise
    task automatic drive(input int x, input bit noise);
        logic [3:0] v;
        i_start = (x == t0) ? 1'b1 : (noise && x > t0 && $urandom_range(0, 2) == 0);
        if (noise && x > t0) i_chan_rdy = 4'($urandom);
        v = noise ? 4'($urandom) : 4'h0;
        for (int k = 0; k < np; k++)
            if (x >= R[k] && x <= L[k])
                v[ord[k]] = !ab[k] && (x >= R[k] + D[k]) && (x < R[k] + D[k] + H[k]);
        i_fd = v;
    endtask

    task automatic idle(input int n, input bit noise);
        repeat (n) begin
            i_start = 1'b0;
            i_fd    = noise ? 4'($urandom) : 4'h0;
            @(negedge clk); #1;
        end
    endtask

    task automatic mid_reset();
        chk("pre_rst_fs", o_fs, 32'(1 << ord[0]));
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_fs", o_fs, 0);
        chk("arst_state", o_so, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_cnt", o_frame_cnt, 0);
        i_start = 1'b0; i_fd = 4'h0;
        @(negedge clk); #1;
        rst = 1'b0;
        fc = 0; base = 0; mptr = 0; np = 0; t0 = BIG; E = BIG; prev_fs = 4'h0;
        chk_en = 1'b1;
        @(negedge clk); #1;
    endtask

    // Runs one frame starting at the next edge; returns positioned before edge E+2
    task automatic run_frame(input logic [3:0] rdy, input logic [3:0] en, input int dfix, input int hfix,
                             input bit noise, input logic [3:0] abm, input int rst_at);
        int x;
        x = cyc + 1;
        i_chan_rdy = rdy; i_chan_en = en;
        seen.delete(); first_fs_edge = -1; done_edge = -1; err_edge = -1;
        plan(rdy & en, x, dfix, hfix, abm);
        while (x <= E + 1) begin
            if (rst_at >= 0 && x == t0 + rst_at) begin
                mid_reset();
                return;
            end
            drive(x, noise);
            @(negedge clk); #1;
            x = cyc + 1;
        end
        i_start = 1'b0;
        i_fd    = 4'h0;
    endtask

    initial begin
        int t_start, d_before;
        rst = 1'b1; i_start = 1'b0; i_chan_en = 4'h0; i_chan_rdy = 4'h0; i_fd = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_fs", o_fs, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_cnt", o_frame_cnt, 0);
        chk("rst_state", o_so, 0);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle(3, 1'b0);

        // Ready 1011 from ptr 0: order 0,1,3
        t_start = cyc + 1;
        run_frame(4'b1011, 4'hF, 5, 2, 1'b0, 4'h0, -1);
        chk("t1_n", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("t1_o0", seen[0], 0); chk("t1_o1", seen[1], 1); chk("t1_o2", seen[2], 3);
        end
        chk("t1_lat", first_fs_edge - t_start, 2);
        chk("t1_cnt", o_frame_cnt, 1);
        chk("t1_dones", done_cnt, 1);

        // Frame ending on ch1 leaves ptr at 2
        run_frame(4'b0011, 4'hF, 5, 2, 1'b0, 4'h0, -1);
        chk("t2a_n", seen.size(), 2);

        // All ready from ptr 2 with stray starts and fd noise: order 2,3,0,1
        d_before = done_cnt;
        run_frame(4'hF, 4'hF, 5, 2, 1'b1, 4'h0, -1);
        chk("t2_n", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("t2_o0", seen[0], 2); chk("t2_o1", seen[1], 3);
            chk("t2_o2", seen[2], 0); chk("t2_o3", seen[3], 1);
        end
        chk("t4_one_done", done_cnt - d_before, 1);
        chk("t2_cnt", o_frame_cnt, 3);

        // Empty snapshot: done after ARB, count still advances
        t_start = cyc + 1;
        run_frame(4'h0, 4'hF, 5, 2, 1'b0, 4'h0, -1);
        chk("t3_n", seen.size(), 0);
        chk("t3_done_lat", done_edge - t_start, 1);
        chk("t3_cnt", o_frame_cnt, 4);

        // Enable masks ready channels; ptr still 2: order 2,0
        run_frame(4'hF, 4'b0101, 5, 2, 1'b0, 4'h0, -1);
        chk("ten_n", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("ten_o0", seen[0], 2); chk("ten_o1", seen[1], 0);
        end

        for (int i = 0; i < 40; i++) begin
            idle(int'($urandom_range(0, 3)), 1'b1);
            run_frame(4'($urandom), 4'($urandom), 0, 0, 1'b1, 4'h0, -1);
        end
        chk("done_total", done_cnt, 45);

        // Reset while the first channel waits for fd
        idle(2, 1'b0);
        run_frame(4'hF, 4'hF, 5, 2, 1'b0, 4'h0, 4);
        idle(2, 1'b0);

        // Normal operation resumes from ptr 0 and count 0
        run_frame(4'b0101, 4'hF, 5, 2, 1'b0, 4'h0, -1);
        chk("t6_n", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("t6_o0", seen[0], 0); chk("t6_o1", seen[1], 2);
        end
        chk("t6_cnt", o_frame_cnt, 1);

`ifdef FRS_TIMEOUT_EN
        // ch1 never answers: abort after 16 WAIT cycles, then ch2 is served
        idle(1, 1'b0);
        t_start = cyc + 1;
        run_frame(4'b0110, 4'hF, 5, 2, 1'b0, 4'b0010, -1);
        chk("t5_err_lat", err_edge - t_start, 2 + TMO);
        chk("t5_n", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("t5_o0", seen[0], 1); chk("t5_o1", seen[1], 2);
        end
        chk("t5_cnt", o_frame_cnt, 2);
`endif

        idle(2, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
